// File: rtl/tdm_mux_param.sv
// Parametrised time-division multiplexer: serialises CHANNELS words of WIDTH bits onto one
// registered output, DWELL cycles per enabled channel, with channel tag and frame-start marker.
module tdm_mux_param #(
   parameter int WIDTH    = 2,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [CHANNELS-1:0]         ch_mask,
   input  logic [CHANNELS*WIDTH-1:0]   in_bus,
   output logic [WIDTH-1:0]            out,
   output logic                        out_valid,
   output logic [$clog2(CHANNELS)-1:0] ch_id,
   output logic                        frame_start
);

   localparam int CW  = $clog2(CHANNELS);
   localparam int DCW = $clog2(DWELL) + 1;
   localparam int unsigned NCH = CHANNELS;

   logic [CW-1:0]    sel;
   logic [DCW-1:0]   dwell_cnt;
   logic [CW-1:0]    next_sel;
   logic [CW-1:0]    first_ch;
   logic             next_found;
   logic             first_found;
   logic [WIDTH-1:0] cur_word;
   logic             slot_end;

   // Walking offsets 1..CHANNELS from sel visits higher indices first, then wraps
   // through 0..sel, so the first hit is next(sel) including the sel-only case.
   always_comb begin
      next_sel   = sel;
      next_found = 1'b0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         int unsigned idx;
         idx = (32'(sel) + i) % NCH;
         if (!next_found && ch_mask[CW'(idx)]) begin
            next_sel   = CW'(idx);
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      first_ch    = '0;
      first_found = 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (!first_found && ch_mask[CW'(k)]) begin
            first_ch    = CW'(k);
            first_found = 1'b1;
         end
      end
   end

   always_comb begin
      cur_word = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (CW'(k) == sel) cur_word = in_bus[k*WIDTH +: WIDTH];
      end
   end

   assign slot_end = (dwell_cnt == DCW'(DWELL - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sel         <= '0;
         dwell_cnt   <= '0;
         out         <= '0;
         out_valid   <= 1'b0;
         ch_id       <= '0;
         frame_start <= 1'b0;
      end else if (!en) begin
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else if (ch_mask == '0) begin
         out         <= '0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else if (!ch_mask[sel]) begin
         sel         <= next_sel;
         dwell_cnt   <= '0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         out         <= cur_word;
         ch_id       <= sel;
         out_valid   <= 1'b1;
         frame_start <= (sel == first_ch) && (dwell_cnt == '0);
         if (slot_end) begin
            dwell_cnt <= '0;
            sel       <= next_sel;
         end else begin
            dwell_cnt <= dwell_cnt + DCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_tdm_mux_param.sv
// Directed bench for tdm_mux_param: one DWELL=1 instance and one DWELL=3 instance on shared inputs.
module tb_tdm_mux_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] ch_mask = 4'b1111;
   logic [7:0] in_bus = '0;

   logic [1:0] out1, out3;
   logic       ov1, ov3;
   logic [1:0] ch1, ch3;
   logic       fs1, fs3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tdm_mux_param #(.WIDTH(2), .CHANNELS(4), .DWELL(1)) dut (
      .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .in_bus(in_bus),
      .out(out1), .out_valid(ov1), .ch_id(ch1), .frame_start(fs1)
   );

   tdm_mux_param #(.WIDTH(2), .CHANNELS(4), .DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .in_bus(in_bus),
      .out(out3), .out_valid(ov3), .ch_id(ch3), .frame_start(fs3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic [3:0] mask);
      rst = 1'b1;
      tick();
      ch_mask = mask;
      en      = 1'b1;
      in_bus  = {2'd0, 2'd3, 2'd2, 2'd1};
      rst     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_bus = 8'($urandom);
         tick();
         n_checks++;
         if ({out1, ov1, ch1, fs1} !== 6'b0 || {out3, ov3, ch3, fs3} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %b/%b expected 000000", i,
                     {out1, ov1, ch1, fs1}, {out3, ov3, ch3, fs3});
         end
      end
   endtask

   task automatic test_rotation();
      logic [1:0] exp_out [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      apply_reset(4'b1111);
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (out1 !== exp_out[i] || ch1 !== 2'(i % 4) || ov1 !== 1'b1 ||
             fs1 !== ((i % 4) == 0)) begin
            n_fail++;
            $display("FAIL rotation[%0d]: got out=%0d ch=%0d ov=%b fs=%b expected out=%0d ch=%0d ov=1 fs=%b",
                     i, out1, ch1, ov1, fs1, exp_out[i], i % 4, (i % 4) == 0);
         end
      end
   endtask

   task automatic test_skip_mask();
      logic       exp_ov [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [1:0] exp_ch [5] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
      logic       exp_fs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0] exp_out[5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
      apply_reset(4'b1010);
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (ov1 !== exp_ov[i] || ch1 !== exp_ch[i] || fs1 !== exp_fs[i] || out1 !== exp_out[i]) begin
            n_fail++;
            $display("FAIL skip_mask[%0d]: got ov=%b ch=%0d fs=%b out=%0d expected ov=%b ch=%0d fs=%b out=%0d",
                     i, ov1, ch1, fs1, out1, exp_ov[i], exp_ch[i], exp_fs[i], exp_out[i]);
         end
      end
   endtask

   task automatic test_dwell_pause();
      logic       exp_ov [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [1:0] exp_ch [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
      logic       exp_fs [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [1:0] exp_out[9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
      apply_reset(4'b1111);
      for (int i = 0; i < 9; i++) begin
         en = !(i == 4 || i == 5);
         tick();
         n_checks++;
         if (ov3 !== exp_ov[i] || ch3 !== exp_ch[i] || fs3 !== exp_fs[i] || out3 !== exp_out[i]) begin
            n_fail++;
            $display("FAIL dwell_pause[%0d]: got ov=%b ch=%0d fs=%b out=%0d expected ov=%b ch=%0d fs=%b out=%0d",
                     i, ov3, ch3, fs3, out3, exp_ov[i], exp_ch[i], exp_fs[i], exp_out[i]);
         end
      end
      en = 1'b1;
   endtask

   task automatic test_mask_zero();
      apply_reset(4'b1111);
      tick();
      tick();
      n_checks++;
      if (out1 !== 2'd2 || ov1 !== 1'b1) begin
         n_fail++;
         $display("FAIL mask_zero_pre: got out=%0d ov=%b expected out=2 ov=1", out1, ov1);
      end
      ch_mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (out1 !== 2'd0 || ov1 !== 1'b0 || fs1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_zero[%0d]: got out=%0d ov=%b fs=%b expected out=0 ov=0 fs=0", i, out1, ov1, fs1);
         end
      end
   endtask

   task automatic test_clear_current();
      apply_reset(4'b1111);
      tick();
      ch_mask = 4'b1110;
      tick();
      n_checks++;
      if (ov3 !== 1'b0 || out3 !== 2'd1 || fs3 !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_idle: got ov=%b out=%0d fs=%b expected ov=0 out=1 fs=0", ov3, out3, fs3);
      end
      tick();
      n_checks++;
      if (ov3 !== 1'b1 || ch3 !== 2'd1 || out3 !== 2'd2 || fs3 !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_next: got ov=%b ch=%0d out=%0d fs=%b expected ov=1 ch=1 out=2 fs=1",
                  ov3, ch3, out3, fs3);
      end
      tick();
      tick();
      tick();
      n_checks++;
      if (ov3 !== 1'b1 || ch3 !== 2'd2 || out3 !== 2'd3) begin
         n_fail++;
         $display("FAIL clear_after: got ov=%b ch=%0d out=%0d expected ov=1 ch=2 out=3", ov3, ch3, out3);
      end
   endtask

   task automatic test_single();
      logic exp_fs3 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      apply_reset(4'b0100);
      tick();
      n_checks++;
      if (ov1 !== 1'b0 || ov3 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: got ov1=%b ov3=%b expected 0 0", ov1, ov3);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (ch1 !== 2'd2 || ov1 !== 1'b1 || fs1 !== 1'b1 || out1 !== 2'd3 ||
             ch3 !== 2'd2 || ov3 !== 1'b1 || fs3 !== exp_fs3[i]) begin
            n_fail++;
            $display("FAIL single[%0d]: got ch=%0d ov=%b fs=%b out=%0d ch3=%0d ov3=%b fs3=%b expected 2 1 1 3 2 1 %b",
                     i, ch1, ov1, fs1, out1, ch3, ov3, fs3, exp_fs3[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset(4'b1111);
      tick();
      tick();
      tick();
      n_checks++;
      if (ch1 !== 2'd2 || out1 !== 2'd3) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got ch=%0d out=%0d expected ch=2 out=3", ch1, out1);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({out1, ov1, ch1, fs1} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got %b expected 000000", {out1, ov1, ch1, fs1});
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (ch1 !== 2'd0 || ov1 !== 1'b1 || fs1 !== 1'b1 || out1 !== 2'd1) begin
         n_fail++;
         $display("FAIL reset_restart: got ch=%0d ov=%b fs=%b out=%0d expected ch=0 ov=1 fs=1 out=1",
                  ch1, ov1, fs1, out1);
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_skip_mask();
      test_dwell_pause();
      test_mask_zero();
      test_clear_current();
      test_single();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
